// File: rtl/cc_miss_req_scheduler.sv
// Miss-request scheduler: logs each accepted miss into the miss-address FIFO and issues one
// 8-beat critical-word-first WRAP read per miss, bounding refills in flight and blocking same-index misses.
module cc_miss_req_scheduler #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_req_valid_i,
  input  logic [31:0] miss_req_addr_i,
  output logic        miss_req_ready_o,
  input  logic        miss_addr_fifo_full_i,
  output logic        miss_addr_fifo_wren_o,
  output logic [31:0] miss_addr_fifo_wdata_o,
  output logic        mem_arvalid_o,
  input  logic        mem_arready_i,
  output logic [31:0] mem_araddr_o,
  output logic [3:0]  mem_arlen_o,
  output logic [2:0]  mem_arsize_o,
  output logic [1:0]  mem_arburst_o,
  input  logic        fill_done_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {IDLE, ADDR} state_t;

  state_t                     state;
  logic [CW-1:0]              out_cnt;
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [8:0]                 tbl_idx [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] tbl_vld;
  logic [31:0]                araddr_q;
  logic                       err_q;
  logic                       conflict;
  logic                       accept;
  logic                       retire;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Compared against the pre-update table, so a slot retiring this cycle still blocks.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (tbl_vld[i] && (tbl_idx[i] == miss_req_addr_i[14:6])) conflict = 1'b1;
    end
  end

  assign miss_req_ready_o = (state == IDLE) && !miss_addr_fifo_full_i &&
                            (out_cnt < CW'(MAX_OUTSTANDING)) && !conflict;
  assign accept = miss_req_valid_i && miss_req_ready_o;
  // A fill with nothing in flight is an error, not a retirement.
  assign retire = fill_done_i && (out_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      out_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tbl_vld  <= '0;
      araddr_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) tbl_idx[i] <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state    <= ADDR;
          araddr_q <= {miss_req_addr_i[31:3], 3'b000};
        end
        ADDR: if (mem_arready_i) state <= IDLE;
        default: state <= IDLE;
      endcase

      // accept needs out_cnt < MAX, so wr_ptr never lands on a slot retiring this cycle.
      if (accept) begin
        tbl_idx[wr_ptr] <= miss_req_addr_i[14:6];
        tbl_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (retire) begin
        tbl_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= ptr_inc(rd_ptr);
      end

      case ({accept, retire})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase

      if (fill_done_i && (out_cnt == '0)) err_q <= 1'b1;
    end
  end

  assign miss_addr_fifo_wren_o  = accept;
  assign miss_addr_fifo_wdata_o = miss_req_addr_i;
  assign mem_arvalid_o          = (state == ADDR);
  assign mem_araddr_o           = araddr_q;
  assign mem_arlen_o            = 4'd7;
  assign mem_arsize_o           = 3'b011;
  assign mem_arburst_o          = 2'b10;
  assign busy_o                 = (out_cnt != '0) || (state != IDLE);
  assign err_o                  = err_q;

endmodule

// File: doc/cc_miss_req_scheduler.md
# cc_miss_req_scheduler

Sequences cache-line refills for the cache controller. It accepts miss requests from the tag-compare stage and logs each miss address into the miss-address FIFO, which the data-fill unit later pops. It then issues one 8-beat critical-word-first WRAP read burst per miss on the AXI AR channel. It also tracks in-flight refills, bounding outstanding reads and blocking a second miss to a set index that is already being filled.

## Interface
- MAX_OUTSTANDING, 2: maximum refills in flight (legal 1..4).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- miss_req_valid_i  in  1  miss request present.
- miss_req_addr_i  in  32  miss byte address; [31:15] tag, [14:6] index, [5:3] word offset.
- miss_req_ready_o  out  1  miss accepted this cycle when high with valid.
- miss_addr_fifo_full_i  in  1  miss-address FIFO full.
- miss_addr_fifo_wren_o  out  1  FIFO push strobe.
- miss_addr_fifo_wdata_o  out  32  pushed address, equal to miss_req_addr_i.
- mem_arvalid_o  out  1  AXI AR valid.
- mem_arready_i  in  1  AXI AR ready.
- mem_araddr_o  out  32  {addr[31:3],3'b000}.
- mem_arlen_o  out  4  constant 4'd7.
- mem_arsize_o  out  3  constant 3'b011.
- mem_arburst_o  out  2  constant 2'b10 (WRAP).
- fill_done_i  in  1  one-cycle pulse when the fill unit writes a refilled line to SRAM.
- busy_o  out  1  outstanding count nonzero or FSM not IDLE.
- err_o  out  1  sticky: fill_done_i received with zero outstanding.

## Operation
- FSM states: IDLE and ADDR. Reset state is IDLE.
- Accept condition: state==IDLE, !miss_addr_fifo_full_i, outstanding < MAX_OUTSTANDING, and no index conflict.
- miss_req_ready_o is the accept condition, computed combinationally. It does not depend on miss_req_valid_i.
- accept = valid & ready. On accept:
  - miss_addr_fifo_wren_o = 1 in the same cycle.
  - Register araddr.
  - Push index [14:6] into the tracking table.
  - Increment outstanding.
  - Move to ADDR.
- ADDR: mem_arvalid_o = 1 with stable araddr. On mem_arready_i, go to IDLE.
- Tracking table:
  - Circular buffer of MAX_OUTSTANDING entries (9-bit index + valid bit), written via wr_ptr and retired via rd_ptr.
  - Pointers wrap modulo MAX_OUTSTANDING.
  - Reads complete in order (single AXI ID), so fill_done_i retires the entry at rd_ptr.
- Conflict: the incoming index equals the index of any valid entry. Comparison uses pre-update table contents, so an entry retiring in the same cycle still blocks. The blocked miss is accepted the next cycle.
- Outstanding counter update:
  - accept and fill_done_i in the same cycle: counter unchanged, both pointers advance.
  - fill_done_i with counter 0: counter and table unchanged, err_o set until reset.
- Counter width is clog2(MAX_OUTSTANDING+1). It never exceeds MAX_OUTSTANDING.

## Timing
- Reset values:
  - miss_req_ready_o reflects IDLE (high if the FIFO is not full).
  - miss_addr_fifo_wren_o=0, mem_arvalid_o=0, mem_araddr_o=0, busy_o=0, err_o=0.
  - Table empty, pointers 0, counter 0.
- Accept in cycle N: FIFO push in N; mem_arvalid_o high from N+1.
- arready sampled high in cycle M: arvalid low in M+1; earliest next accept in M+1.
- Peak throughput: one miss per 2 cycles.
- mem_araddr_o must not change while arvalid is high and arready is low.
- A fill_done_i in cycle K frees its slot and index for an accept in K+1.
- rst asserted mid-burst-issue: arvalid drops immediately (asynchronous). Pending table state is discarded.

## Test plan
- Single miss 0x0001_2348, arready high: FIFO push in cycle N with data 0x0001_2348; araddr 0x0001_2348, arlen 7, arburst 2'b10 in N+1; busy_o stays high until fill_done_i.
- MAX_OUTSTANDING=2, three misses to indices 1, 2, 3 with no fill_done_i: first two accepted; third held with ready=0; fill_done_i pulse, then third accepted the cycle after.
- Miss to index 0x05 outstanding, new miss to the same index with a different tag: ready=0. fill_done_i and the request in the same cycle: still blocked; accepted the next cycle.
- mem_arready_i held low 5 cycles: arvalid and araddr stable; no new accept; FIFO push count stays 1.
- miss_addr_fifo_full_i high with a valid miss: ready=0, no push, no AR issued. Full drops: accept within the same cycle.
- fill_done_i with counter 0: err_o=1 and stays set; counter stays 0. Async rst mid-ADDR clears arvalid and err_o without a clock edge.
